// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding shared by the ALU compute core and its register stage
package alu_pkg;
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational N-bit add/sub/and/or core producing result and status flags
module alu_comb
  import alu_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   sel,
  output logic [N-1:0] res,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);
  logic [N:0] sum;
  logic [N:0] dif;
  logic       is_add;
  logic       is_sub;
  assign sum    = {1'b0, a} + {1'b0, b};
  assign dif    = {1'b0, a} - {1'b0, b};
  assign is_add = sel == OP_ADD;
  assign is_sub = sel == OP_SUB;
  always_comb begin
    res  = is_add ? sum[N-1:0] : is_sub ? dif[N-1:0] : sel == OP_AND ? a & b : a | b;
    cout = is_add ? sum[N] : is_sub ? dif[N] : 1'b0;
    ovf  = is_add ? (a[N-1] == b[N-1]) && (res[N-1] != a[N-1]) :
           is_sub ? (a[N-1] != b[N-1]) && (res[N-1] != a[N-1]) : 1'b0;
    zero = res == '0;
    neg  = res[N-1];
  end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: registered N-bit ALU with one-cycle latency, valid pipeline and sync active-low reset
module alu_unit
  import alu_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   sel,
  output logic         out_valid,
  output logic [N-1:0] res,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);
  logic [N-1:0] c_res;
  logic         c_cout;
  logic         c_ovf;
  logic         c_zero;
  logic         c_neg;
  logic [N-1:0] res_d, res_q;
  logic         cout_d, cout_q;
  logic         ovf_d, ovf_q;
  logic         zero_d, zero_q;
  logic         neg_d, neg_q;
  logic         vld_d, vld_q;
  alu_comb #(.N(N)) u_comb (
    .a    (a),
    .b    (b),
    .sel  (sel),
    .res  (c_res),
    .cout (c_cout),
    .ovf  (c_ovf),
    .zero (c_zero),
    .neg  (c_neg)
  );
  always_comb begin
    vld_d  = in_valid;
    res_d  = in_valid ? c_res  : res_q;
    cout_d = in_valid ? c_cout : cout_q;
    ovf_d  = in_valid ? c_ovf  : ovf_q;
    zero_d = in_valid ? c_zero : zero_q;
    neg_d  = in_valid ? c_neg  : neg_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      res_q  <= res_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end
  assign out_valid = vld_q;
  assign res       = res_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and random scoreboard bench for alu_unit at N=2
module tb_alu_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] a = '0;
  logic [1:0] b = '0;
  logic [1:0] sel = '0;
  logic       out_valid;
  logic [1:0] res;
  logic       cout;
  logic       ovf;
  logic       zero;
  logic       neg;
  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] exp_st = 7'b0_00_0_0_1_0;
  logic [6:0] sb[$];
  alu_unit #(.N(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .res       (res),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] model(input logic [1:0] ma, input logic [1:0] mb, input logic [1:0] ms);
    int ua, ub, sa, sb_, r, sr;
    logic c, o;
    logic [1:0] rr;
    ua = int'(ma);
    ub = int'(mb);
    sa = ua >= 2 ? ua - 4 : ua;
    sb_ = ub >= 2 ? ub - 4 : ub;
    c = 1'b0;
    o = 1'b0;
    case (ms)
      2'd0: begin r = ua + ub; c = r > 3; sr = sa + sb_; o = sr > 1 || sr < -2; end
      2'd1: begin r = ua - ub; c = ua < ub; sr = sa - sb_; o = sr > 1 || sr < -2; end
      2'd2: r = ua & ub;
      default: r = ua | ub;
    endcase
    r = (r + 4) % 4;
    rr = r[1:0];
    return {1'b1, rr, c, o, rr == 2'b00, rr[1]};
  endfunction
  task automatic step(input logic v, input logic [1:0] ta, input logic [1:0] tb_, input logic [1:0] ts,
                      input logic rn, input string tag);
    logic [6:0] obs, ex;
    rst_n = rn;
    in_valid = v;
    a = ta;
    b = tb_;
    sel = ts;
    if (!rn) exp_st = 7'b0_00_0_0_1_0;
    else if (v) exp_st = model(ta, tb_, ts);
    else exp_st[6] = 1'b0;
    sb.push_back(exp_st);
    @(posedge clk);
    #1;
    obs = {out_valid, res, cout, ovf, zero, neg};
    ex = sb.pop_front();
    n_vec++;
    assert (obs === ex) else begin
      n_err++;
      $error("FAIL %s {vld,res,cout,ovf,zero,neg} observed=%b expected=%b", tag, obs, ex);
    end
  endtask
  task automatic fld(input string tag, input logic [6:0] obs, input logic [6:0] ex);
    n_vec++;
    assert (obs === ex) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, ex);
    end
  endtask
  initial begin
    step(1'b1, 2'b01, 2'b01, 2'b00, 1'b0, "reset0");
    step(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, "reset1");
    fld("reset_const", {out_valid, res, cout, ovf, zero, neg}, 7'b0_00_0_0_1_0);
    step(1'b1, 2'b01, 2'b10, 2'b00, 1'b1, "add_01_10");
    fld("add_01_10_const", {out_valid, res, cout, ovf, zero, neg}, 7'b1_11_0_0_0_1);
    step(1'b1, 2'b11, 2'b00, 2'b01, 1'b1, "sub_11_00");
    fld("sub_11_00_const", {5'b0, res}, 7'b00000_11);
    fld("sub_11_00_cout", {6'b0, cout}, 7'd0);
    step(1'b1, 2'b11, 2'b10, 2'b10, 1'b1, "and_11_10");
    fld("and_11_10_const", {5'b0, res}, 7'b00000_10);
    step(1'b1, 2'b10, 2'b11, 2'b11, 1'b1, "or_10_11");
    fld("or_10_11_const", {5'b0, res}, 7'b00000_11);
    step(1'b1, 2'b11, 2'b01, 2'b00, 1'b1, "add_wrap");
    fld("add_wrap_const", {out_valid, res, cout, ovf, zero, neg}, 7'b1_00_1_0_1_0);
    step(1'b1, 2'b01, 2'b01, 2'b00, 1'b1, "add_ovf");
    fld("add_ovf_const", {out_valid, res, cout, ovf, zero, neg}, 7'b1_10_0_1_0_1);
    step(1'b1, 2'b00, 2'b01, 2'b01, 1'b1, "sub_borrow");
    fld("sub_borrow_const", {4'b0, res, cout}, 7'b0000_11_1);
    fld("sub_borrow_neg", {6'b0, neg}, 7'd1);
    step(1'b1, 2'b10, 2'b01, 2'b01, 1'b1, "sub_ovf");
    fld("sub_ovf_const", {4'b0, res, ovf}, 7'b0000_01_1);
    step(1'b1, 2'b01, 2'b10, 2'b00, 1'b1, "hold_pre");
    step(1'b0, 2'b01, 2'b01, 2'b00, 1'b1, "hold0");
    step(1'b0, 2'b11, 2'b10, 2'b01, 1'b1, "hold1");
    fld("hold_const", {out_valid, 4'b0, res}, 7'b0_0000_11);
    step(1'b1, 2'b01, 2'b01, 2'b00, 1'b0, "mid_reset");
    fld("mid_reset_const", {out_valid, 4'b0, res}, 7'b0_0000_00);
    step(1'b1, 2'b01, 2'b10, 2'b11, 1'b1, "post_reset_or");
    fld("post_reset_or_const", {out_valid, 4'b0, res}, 7'b1_0000_11);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1, "b2b_rand");
      fld("b2b_valid", {6'b0, out_valid}, 7'd1);
    end
    step(1'b0, 2'b00, 2'b00, 2'b00, 1'b1, "drain");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_unit.md
# alu_unit

Registered N-bit arithmetic/logic unit for the datapath. Takes two unsigned operands and a 2-bit operation select, and computes add, subtract, AND or OR. Result and status flags are registered with a one-cycle latency. It is a leaf block, driven by upstream control and consumed by downstream registers or a writeback path.

## Interface
Clock and reset:
- One clock; reset is synchronous and active-low.

Parameters:
- N, default 2: operand and result width in bits. Legal range is N ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands and select are valid this cycle
- a  input  N  operand A, unsigned
- b  input  N  operand B, unsigned
- sel  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 OR
- out_valid  output  1  res and flags hold a new result
- res  output  N  result
- cout  output  1  ADD: carry out; SUB: borrow (1 when a < b unsigned); logic ops: 0
- ovf  output  1  signed (two's-complement) overflow for ADD/SUB; 0 for logic ops
- zero  output  1  res == 0
- neg  output  1  res[N-1]

## Operation
- ADD: res = (a + b) mod 2^N; cout = bit N of the (N+1)-bit sum.
- SUB: res = (a − b) mod 2^N; cout = (a < b).
- AND: res = a & b, bitwise.
- OR: res = a | b, bitwise.
- ovf for ADD = (a[N-1] == b[N-1]) && (res[N-1] != a[N-1]).
- ovf for SUB = (a[N-1] != b[N-1]) && (res[N-1] != a[N-1]).
- zero and neg are derived from the N-bit result being registered, not from the wide internal sum.
- All arithmetic is computed at N+1 bits internally, then truncated to N bits.
- No illegal opcodes: all four sel codes are defined.

## Timing
- Latency is 1 cycle. Inputs sampled at edge k with in_valid=1 appear on res and flags after edge k, with out_valid=1.
- out_valid <= in_valid every cycle. There is no backpressure, so a new operation is accepted every cycle.
- When in_valid=0, res and flags hold their previous values and out_valid falls to 0.
- Reset: while rst_n=0 at a clock edge, res=0, cout=0, ovf=0, neg=0, out_valid=0, and zero=1 (consistent with res=0).
- Reset dominates in_valid. An operation presented in the same cycle as reset is dropped.
- Reset mid-stream: the result in flight is discarded. The first valid input after rst_n returns high produces output one cycle later.
- Outputs are driven only by flops; there is no combinational path from inputs to outputs.

## Structure
- Shared package alu_pkg holds the opcode localparams/enum (OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11).
- Sub-module alu_comb is a purely combinational N-bit compute core producing the next-state res, cout, ovf, zero and neg.
- Top module alu_unit instantiates alu_comb and adds the output register stage, valid pipeline and reset.

## Test plan
All scenarios use N=2.
- Reset: hold rst_n=0 for 2 cycles → out_valid=0, res=00, zero=1, cout=0, ovf=0, neg=0.
- Directed ops, one per cycle with in_valid=1:
  - ADD a=01 b=10 → res=11, cout=0, ovf=0, neg=1.
  - SUB a=11 b=00 → res=11, cout=0.
  - AND a=11 b=10 → res=10.
  - OR a=10 b=11 → res=11.
  - Each result appears exactly one cycle after its input.
- Wrap and flags:
  - ADD a=11 b=01 → res=00, cout=1, zero=1, ovf=0.
  - ADD a=01 b=01 → res=10, ovf=1.
  - SUB a=00 b=01 → res=11, cout=1 (borrow), neg=1.
  - SUB a=10 b=01 → res=01, ovf=1.
- Hold: after a valid ADD giving 11, drive in_valid=0 with changing a/b → out_valid=0, res stays 11.
- Reset mid-stream: in_valid=1 ADD 01+01 with rst_n=0 in the same cycle → next cycle out_valid=0, res=00. After rst_n=1, OR 01|10 → res=11 with out_valid=1 one cycle later.
- Back-to-back: 8 consecutive valid random ops → out_valid stays 1, and every res/flag set matches the reference model with 1-cycle lag.
